// File: rtl/trace_sequencer.sv
// Spell-trace pad sequencer: records the order in which grid cells are first
// touched, one cell per clock, lowest index first when several arrive together.
module trace_sequencer #(
  parameter int         CELLS      = 25,
  parameter logic [4:0] EMPTY_CODE = 5'd31
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CELLS-1:0]     inTrace,
  output logic [5*CELLS-1:0]   order,
  output logic [4:0]           count,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = 5;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [CELLS-1:0] hit;
  logic [CELLS-1:0] seen;
  logic [CELLS-1:0] hit_nx;
  logic [CELLS-1:0] pend;
  logic [IW-1:0]    pick;
  logic             any;
  logic             multi;
  logic             full;

  // Live touches only count while recording; DRAIN works off the held hit mask.
  always_comb begin
    hit_nx = hit | inTrace;
    pend   = (state == RECORD) ? (hit_nx & ~seen) : (hit & ~seen);
    any    = |pend;
    multi  = |(pend & (pend - CELLS'(1)));
    full   = any && (count == IW'(CELLS - 1));
  end

  // Scan downward so the last match wins, leaving the lowest set index.
  always_comb begin
    pick = '0;
    for (int unsigned i = CELLS; i > 0; i--) begin
      if (pend[i-1]) pick = IW'(i - 1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      order <= {CELLS{EMPTY_CODE}};
      count <= '0;
      hit   <= '0;
      seen  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      state <= RECORD;
      order <= {CELLS{EMPTY_CODE}};
      count <= '0;
      hit   <= '0;
      seen  <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        RECORD: begin
          hit <= hit_nx;
          if (any) begin
            order[int'(count)*IW +: IW] <= pick;
            seen[pick]                  <= 1'b1;
            count                       <= count + 5'd1;
          end
          // A stop with a single pending cell finishes here since that cell lands now.
          if (full || (stop && !multi)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (stop) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (any) begin
            order[int'(count)*IW +: IW] <= pick;
            seen[pick]                  <= 1'b1;
            count                       <= count + 5'd1;
          end
          if (full || !multi) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer with hand-computed touch orders.
module tb_trace_sequencer;

  logic         clock;
  logic         reset;
  logic         start;
  logic         stop;
  logic [24:0]  inTrace;
  logic [124:0] order;
  logic [4:0]   count;
  logic         busy;
  logic         done;

  int unsigned  n_cmp;
  int unsigned  n_bad;
  logic [124:0] exp_order;

  trace_sequencer #(.CELLS(25), .EMPTY_CODE(5'd31)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .inTrace (inTrace),
    .order   (order),
    .count   (count),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_clear();
    exp_order = '1;
  endtask

  task automatic exp_put(input int unsigned k, input logic [4:0] v);
    exp_order[k*5 +: 5] = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_clear();
  endtask

  int unsigned sweep [25];

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    inTrace = '0;
    exp_clear();
    #12;
    check("rst_order", order, exp_order);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // cells 12, 7, 3 then stop
    pulse_start();
    check("s1_busy", busy, 1);
    check("s1_count0", count, 0);
    inTrace = 25'd1 << 12; tick();
    check("s1_lat_count", count, 1);
    check("s1_lat_slot0", order[4:0], 12);
    inTrace = 25'd1 << 7; tick();
    inTrace = 25'd1 << 3; tick();
    inTrace = '0; stop = 1'b1; tick(); stop = 1'b0;
    exp_put(0, 12); exp_put(1, 7); exp_put(2, 3);
    check("s1_order", order, exp_order);
    check("s1_count", count, 3);
    check("s1_done", done, 1);
    check("s1_busy_off", busy, 0);
    tick();
    check("s1_hold", order, exp_order);

    // cells 5 and 2 together for one cycle
    pulse_start();
    check("s2_cleared", order, exp_order);
    inTrace = (25'd1 << 5) | (25'd1 << 2); tick();
    inTrace = '0;
    check("s2_slot0", order[4:0], 2);
    check("s2_count1", count, 1);
    tick();
    check("s2_slot1", order[9:5], 5);
    check("s2_count2", count, 2);
    stop = 1'b1; tick(); stop = 1'b0;
    check("s2_done", done, 1);

    // four cells at once, stop while three still pending -> DRAIN
    pulse_start();
    inTrace = 25'h000000F; tick();
    inTrace = '0; stop = 1'b1; tick(); stop = 1'b0;
    check("s3_drain_busy", busy, 1);
    check("s3_drain_done", done, 0);
    check("s3_drain_count", count, 2);
    inTrace = 25'd1 << 20; tick();
    inTrace = '0;
    check("s3_drain_count3", count, 3);
    tick();
    exp_put(0, 0); exp_put(1, 1); exp_put(2, 2); exp_put(3, 3);
    check("s3_order", order, exp_order);
    check("s3_count", count, 4);
    check("s3_done", done, 1);

    // full sweep in order 7k mod 25, cell 9 re-touched, no stop
    pulse_start();
    for (int unsigned k = 0; k < 25; k++) begin
      sweep[k] = (k * 7) % 25;
    end
    for (int unsigned k = 0; k < 25; k++) begin
      inTrace = 25'd1 << sweep[k];
      tick();
      exp_put(k, 5'(sweep[k]));
      if (sweep[k] == 9) begin
        inTrace = 25'd1 << 9; tick();
        check("s4_retouch_count", count, k + 1);
      end
    end
    inTrace = '0;
    check("s4_order", order, exp_order);
    check("s4_count", count, 25);
    check("s4_done", done, 1);
    check("s4_busy", busy, 0);
    stop = 1'b1; inTrace = '1; tick(); stop = 1'b0; inTrace = '0;
    check("s4_hold_count", count, 25);
    check("s4_hold_order", order, exp_order);

    // start and stop together act as start
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    exp_clear();
    check("s5_busy", busy, 1);
    check("s5_done", done, 0);
    check("s5_order", order, exp_order);

    // reset in the middle of a recording
    for (int unsigned c = 1; c <= 4; c++) begin
      inTrace = 25'd1 << c; tick();
    end
    inTrace = '0;
    check("s6_count4", count, 4);
    reset = 1'b1; #2;
    check("s6_async_count", count, 0);
    check("s6_async_order", order, exp_order);
    check("s6_async_busy", busy, 0);
    tick(); reset = 1'b0;
    stop = 1'b1; inTrace = 25'd1 << 6; tick(); stop = 1'b0; inTrace = '0;
    tick();
    check("s6_idle_busy", busy, 0);
    check("s6_idle_count", count, 0);
    check("s6_idle_done", done, 0);
    pulse_start();
    inTrace = 25'd1 << 20; tick(); inTrace = '0;
    exp_put(0, 20);
    check("s6_order", order, exp_order);
    check("s6_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
